wb_bus_watchdog: RTL and testbench

- Wishbone classic pass-through stage between the AXI4-Lite-to-Wishbone bridge (master side) and the core/data memory port (slave side).
- Counts cycles of each outstanding request; if the slave does not ack within TIMEOUT_CYCLES, aborts the slave cycle and returns a one-cycle error to the bridge.
- A hung memory or controller therefore cannot freeze the core, and the faulting access is recorded for debug.

---
 rtl/wb_bus_watchdog.sv | 139 +++++++++++++
 tb/tb_wb_bus_watchdog.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_watchdog.sv
// Wishbone classic pass-through with a per-request ack timeout.
// Hung slave cycles are aborted with a one-cycle error and logged.
module wb_bus_watchdog #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    clr_i,
  input  logic                    s_cyc_i,
  input  logic                    s_stb_i,
  input  logic                    s_we_i,
  input  logic [DATA_WIDTH/8-1:0] s_sel_i,
  input  logic [ADDR_WIDTH-1:0]   s_adr_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_ack_o,
  output logic                    s_err_o,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_sel_o,
  output logic [ADDR_WIDTH-1:0]   m_adr_o,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  input  logic                    m_ack_i,
  output logic                    irq_o,
  output logic [ADDR_WIDTH-1:0]   fault_adr_o,
  output logic                    fault_we_o,
  output logic [15:0]             timeout_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    ABORT = 2'b10
  } state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    irq_q, irq_d;
  logic [ADDR_WIDTH-1:0]   fault_adr_q, fault_adr_d;
  logic                    fault_we_q, fault_we_d;
  logic [15:0]             tcnt_q, tcnt_d;
  logic                    timeout;
  logic                    abort;

  // Request tracking FSM, cycle counter and fault log
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    irq_d       = irq_q;
    fault_adr_d = fault_adr_q;
    fault_we_d  = fault_we_q;
    tcnt_d      = tcnt_q;
    timeout     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i && !m_ack_i && enable_i) begin
          state_d = BUSY;
          cnt_d   = 16'd1;
        end
      end
      BUSY: begin
        if (m_ack_i || !s_stb_i || !s_cyc_i || !enable_i) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == LAST) begin
          state_d = ABORT;
          cnt_d   = 16'd0;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    // a timeout beats a simultaneous clear
    if (timeout) begin
      irq_d       = 1'b1;
      fault_adr_d = s_adr_i;
      fault_we_d  = s_we_i;
      if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
    end else if (clr_i) begin
      irq_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      irq_q       <= 1'b0;
      fault_adr_q <= '0;
      fault_we_q  <= 1'b0;
      tcnt_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      irq_q       <= irq_d;
      fault_adr_q <= fault_adr_d;
      fault_we_q  <= fault_we_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Zero-latency forwarding, overridden during the abort cycle
  always_comb begin
    abort   = (state_q == ABORT);
    m_cyc_o = s_cyc_i & ~abort & ~rst;
    m_stb_o = s_stb_i & ~abort & ~rst;
    m_we_o  = s_we_i;
    m_sel_o = s_sel_i;
    m_adr_o = s_adr_i;
    m_dat_o = s_dat_i;
    s_dat_o = abort ? ERR_DATA : m_dat_i;
    s_ack_o = m_ack_i & s_stb_i & ~abort & ~rst;
    s_err_o = abort & ~rst;
  end

  assign irq_o         = irq_q;
  assign fault_adr_o   = fault_adr_q;
  assign fault_we_o    = fault_we_q;
  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Directed bench for wb_bus_watchdog with TIMEOUT_CYCLES = 8.
// Expected responses are queued at issue and popped on s_ack_o/s_err_o.
module tb_wb_bus_watchdog;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i, clr_i;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_adr_i, s_dat_i, s_dat_o;
  logic        s_ack_o, s_err_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic        m_ack_i;
  logic        irq_o;
  logic [31:0] fault_adr_o;
  logic        fault_we_o;
  logic [15:0] timeout_cnt_o;

  typedef struct {
    bit          err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_cnt0 = 0;

  wb_bus_watchdog #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .enable_i(enable_i), .clr_i(clr_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
    .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .s_err_o(s_err_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .irq_o(irq_o), .fault_adr_o(fault_adr_o),
    .fault_we_o(fault_we_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. ack_at = 0 means the slave never acks.
  task automatic req(input logic we, input logic [31:0] adr,
                     input logic [31:0] wdat, input int ack_at,
                     input logic [31:0] rdat, input bit stray,
                     input int clr_at, input bit hold, input int exp_cyc);
    exp_t e;
    exp_t g;
    bit   done;
    e.err = (exp_cyc == T + 1);
    e.dat = e.err ? 32'hDEAD_BEEF : rdat;
    e.cyc = exp_cyc;
    exp_q.push_back(e);
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i  = we;
    s_sel_i = 4'hF;
    s_adr_i = adr;
    s_dat_i = wdat;
    done = 0;
    for (int n = 1; n <= 60 && !done; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      m_ack_i = (n == ack_at) || (stray && n == T + 1);
      m_dat_i = rdat;
      clr_i   = (n == clr_at);
      @(negedge clk);
      if (chk_cnt0 && n == 20) chk("cnt_held", 64'(dut.cnt_q), 0);
      if (s_ack_o || s_err_o) begin
        done = 1;
        g = exp_q.pop_front();
        chk("resp_err", 64'(s_err_o), 64'(g.err));
        chk("resp_ack", 64'(s_ack_o), 64'(!g.err));
        chk("resp_dat", 64'(s_dat_o), 64'(g.dat));
        chk("resp_cyc", 64'(n), 64'(g.cyc));
        if (g.err) chk("abort_cyc", 64'(m_cyc_o), 0);
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $error("FAIL resp_wait: got none expected response");
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    m_ack_i = 1'b0;
    clr_i   = 1'b0;
    if (!hold) begin
      s_cyc_i = 1'b0;
      s_stb_i = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    enable_i = 1'b1;
    clr_i = 1'b0;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i = 1'b0;
    s_sel_i = 4'h0;
    s_adr_i = '0;
    s_dat_i = '0;
    m_dat_i = '0;
    m_ack_i = 1'b1;
    #3;
    chk("rst_ack", 64'(s_ack_o), 0);
    chk("rst_err", 64'(s_err_o), 0);
    chk("rst_cyc", 64'(m_cyc_o), 0);
    chk("rst_stb", 64'(m_stb_o), 0);
    chk("rst_irq", 64'(irq_o), 0);
    chk("rst_tcnt", 64'(timeout_cnt_o), 0);
    chk("rst_fadr", 64'(fault_adr_o), 0);
    chk("rst_fwe", 64'(fault_we_o), 0);
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    m_ack_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    req(1'b0, 32'h100, 32'h0, 3, 32'h1234_5678, 0, 0, 0, 3);
    chk("t1_irq", 64'(irq_o), 0);
    chk("t1_tcnt", 64'(timeout_cnt_o), 0);

    req(1'b0, 32'h200, 32'h0, T, 32'hCAFE_F00D, 0, 0, 0, T);
    chk("t2_irq", 64'(irq_o), 0);

    req(1'b1, 32'h8000_0040, 32'h55AA_55AA, 0, 32'h1111_1111,
        1, 0, 1, T + 1);
    chk("t3_fadr", 64'(fault_adr_o), 64'h8000_0040);
    chk("t3_fwe", 64'(fault_we_o), 1);
    chk("t3_irq", 64'(irq_o), 1);
    chk("t3_tcnt", 64'(timeout_cnt_o), 1);
    req(1'b0, 32'h4, 32'h0, 2, 32'h0BAD_C0DE, 0, 0, 0, 2);
    chk("t4_tcnt", 64'(timeout_cnt_o), 1);

    req(1'b0, 32'h0000_0800, 32'h0, 0, 32'h0, 0, T, 0, T + 1);
    chk("t5_irq", 64'(irq_o), 1);
    chk("t5_tcnt", 64'(timeout_cnt_o), 2);
    chk("t5_fadr", 64'(fault_adr_o), 64'h800);
    chk("t5_fwe", 64'(fault_we_o), 0);
    clr_i = 1'b1;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    chk("t5_clr", 64'(irq_o), 0);

    enable_i = 1'b0;
    chk_cnt0 = 1;
    req(1'b0, 32'h900, 32'h0, 50, 32'hA5A5_0001, 0, 0, 0, 50);
    chk_cnt0 = 0;
    chk("t6_tcnt", 64'(timeout_cnt_o), 2);
    enable_i = 1'b1;

    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_adr_i = 32'h300;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_busy", 64'(dut.state_q), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_state", 64'(dut.state_q), 0);
    chk("t7_cyc", 64'(m_cyc_o), 0);
    chk("t7_err", 64'(s_err_o), 0);
    chk("t7_tcnt", 64'(timeout_cnt_o), 0);
    chk("t7_fadr", 64'(fault_adr_o), 0);
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t7_idle_err", 64'(s_err_o), 0);
    chk("sb_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
